// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared bus widths, mem_op codes and stall/zero constants for the memory stage
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 212;
    localparam int MEM_TO_WB_WD = 136;
    localparam int MEM_TO_ID_WD = 104;

    typedef enum logic [3:0] {
        MEM_OP_NONE = 4'd0,
        MEM_OP_LB   = 4'd1,
        MEM_OP_LBU  = 4'd2,
        MEM_OP_LH   = 4'd3,
        MEM_OP_LHU  = 4'd4,
        MEM_OP_LW   = 4'd5,
        MEM_OP_SB   = 4'd6,
        MEM_OP_SH   = 4'd7,
        MEM_OP_SW   = 4'd8
    } mem_op_e;

    localparam logic        STOP      = 1'b1;
    localparam logic        NO_STOP   = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_OP_LB) || (op == MEM_OP_LBU) || (op == MEM_OP_LH) ||
               (op == MEM_OP_LHU) || (op == MEM_OP_LW);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - little-endian byte/half select and sign/zero extension of a load word
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [3:0]  mem_op,
    input  logic [1:0]  addr,
    input  logic [31:0] word,
    output logic [31:0] value
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed byte/half, then extend according to the load flavour
    always_comb begin
        byte_v = word[{addr, 3'b000} +: 8];
        half_v = addr[1] ? word[31:16] : word[15:0];
        case (mem_op)
            MEM_OP_LB:  value = {{24{byte_v[7]}}, byte_v};
            MEM_OP_LBU: value = {24'h0, byte_v};
            MEM_OP_LH:  value = {{16{half_v[15]}}, half_v};
            MEM_OP_LHU: value = {16'h0, half_v};
            MEM_OP_LW:  value = word;
            default:    value = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage: EX/MEM register, stall-safe load capture, write-back and forwarding buses (option MEM_ADDR_EXC_EN)
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus,
    output logic                    mem_excp,
    output logic [31:0]             mem_badvaddr
);

    logic [EX_TO_MEM_WD-1:0] bus_r;
    logic [31:0]             ld_word;
    logic                    ld_vld;

    logic [3:0]  mem_op;
    logic        hi_we, lo_we, r_lo, r_hi;
    logic [31:0] hi_wdata, lo_wdata, r_lo_data, r_hi_data, pc, ex_result;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res, rf_we;
    logic [4:0]  rf_waddr;

    logic        bubble;
    logic        reload;
    logic [31:0] rd_word;
    logic [31:0] ld_value;
    logic [31:0] rf_wdata;
    logic        rf_we_o, hi_we_o, lo_we_o;

    assign mem_op       = bus_r[211:208];
    assign hi_we        = bus_r[207];
    assign hi_wdata     = bus_r[206:175];
    assign lo_we        = bus_r[174];
    assign lo_wdata     = bus_r[173:142];
    assign r_lo         = bus_r[141];
    assign r_lo_data    = bus_r[140:109];
    assign r_hi         = bus_r[108];
    assign r_hi_data    = bus_r[107:76];
    assign pc           = bus_r[75:44];
    assign data_ram_en  = bus_r[43];
    assign data_ram_wen = bus_r[42:39];
    assign sel_rf_res   = bus_r[38];
    assign rf_we        = bus_r[37];
    assign rf_waddr     = bus_r[36:32];
    assign ex_result    = bus_r[31:0];

    // Execute stalled while memory runs: insert a bubble. Any non-hold case reloads bus_r.
    assign bubble = (stall[3] == STOP) && (stall[4] == NO_STOP);
    assign reload = (stall[3] == NO_STOP) || bubble;

    // EX/MEM pipeline register: bubble on execute-only stall, hold on full stall
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_r <= '0;
        end else if (bubble) begin
            bus_r <= '0;
        end else if (stall[3] == NO_STOP) begin
            bus_r <= ex_to_mem_bus;
        end
    end

    // Freeze the SRAM word seen on the first held cycle so a long stall keeps the load value
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_word <= ZERO_WORD;
            ld_vld  <= 1'b0;
        end else if (reload) begin
            ld_vld  <= 1'b0;
        end else if (!ld_vld) begin
            ld_word <= data_sram_rdata;
            ld_vld  <= 1'b1;
        end
    end

    assign rd_word = ld_vld ? ld_word : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .mem_op (mem_op),
        .addr   (ex_result[1:0]),
        .word   (rd_word),
        .value  (ld_value)
    );

    // Register-file write value: HI/LO moves win over loads, loads over the ALU result
    always_comb begin
        if (r_hi) begin
            rf_wdata = r_hi_data;
        end else if (r_lo) begin
            rf_wdata = r_lo_data;
        end else if (sel_rf_res && is_load(mem_op)) begin
            rf_wdata = ld_value;
        end else begin
            rf_wdata = ex_result;
        end
    end

`ifdef MEM_ADDR_EXC_EN
    logic half_op, word_op;

    assign half_op      = (mem_op == MEM_OP_LH) || (mem_op == MEM_OP_LHU) || (mem_op == MEM_OP_SH);
    assign word_op      = (mem_op == MEM_OP_LW) || (mem_op == MEM_OP_SW);
    assign mem_excp     = (half_op && ex_result[0]) || (word_op && (ex_result[1:0] != 2'b00));
    assign mem_badvaddr = mem_excp ? ex_result : ZERO_WORD;
    assign rf_we_o      = rf_we & ~mem_excp;
    assign hi_we_o      = hi_we & ~mem_excp;
    assign lo_we_o      = lo_we & ~mem_excp;
`else
    assign mem_excp     = 1'b0;
    assign mem_badvaddr = ZERO_WORD;
    assign rf_we_o      = rf_we;
    assign hi_we_o      = hi_we;
    assign lo_we_o      = lo_we;
`endif

    assign mem_to_wb_bus = {hi_we_o, hi_wdata, lo_we_o, lo_wdata, pc,
                            rf_we_o, rf_waddr, rf_wdata};
    assign mem_to_id_bus = {hi_we_o, hi_wdata, lo_we_o, lo_wdata,
                            rf_we_o, rf_waddr, rf_wdata};

    // Stall bits owned by other stages and the SRAM request fields are consumed upstream
    logic unused_ok;
    assign unused_ok = ^{stall[5], stall[2:0], data_ram_en, data_ram_wen};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized model-checked bench for mem_stage plus literal test-plan cases
module tb_mem_stage;

    logic         clk;
    logic         rst;
    logic [5:0]   stall;
    logic [211:0] ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic [135:0] mem_to_wb_bus;
    logic [103:0] mem_to_id_bus;
    logic         mem_excp;
    logic [31:0]  mem_badvaddr;

    int tests = 0;
    int fails = 0;

    // Reference state: what the stage currently holds and the load word it has committed to
    logic [211:0] m_bus;
    logic         m_first;
    logic [31:0]  m_word;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id_bus   (mem_to_id_bus),
        .mem_excp        (mem_excp),
        .mem_badvaddr    (mem_badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ld_ext(input logic [3:0] op, input logic [1:0] a, input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = a[1] ? (w >> 16) : (w & 32'hFFFF);
        case (op)
            4'd1: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            4'd2: return b;
            4'd3: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            4'd4: return h;
            4'd5: return w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [211:0] pkt(input logic [3:0] op, input logic [31:0] res, input logic sel,
                                         input logic we, input logic [4:0] wa, input logic [31:0] pcv);
        logic [211:0] p;
        p = '0;
        p[211:208] = op;
        p[31:0]    = res;
        p[38]      = sel;
        p[37]      = we;
        p[36:32]   = wa;
        p[75:44]   = pcv;
        return p;
    endfunction

    // Compare every output with what the spec rules give for the current stage contents
    task automatic compare_model();
        logic [3:0]   op;
        logic [31:0]  res, w, wd, bad;
        logic         excp, ld, rfwe, hiwe, lowe;
        logic [135:0] ewb;
        logic [103:0] eid;
        op  = m_bus[211:208];
        res = m_bus[31:0];
        w   = m_first ? data_sram_rdata : m_word;
        ld  = (op >= 4'd1) && (op <= 4'd5);
        if (m_bus[108])              wd = m_bus[107:76];
        else if (m_bus[141])         wd = m_bus[140:109];
        else if (m_bus[38] && ld)    wd = ld_ext(op, res[1:0], w);
        else                         wd = res;
`ifdef MEM_ADDR_EXC_EN
        excp = ((op == 4'd3 || op == 4'd4 || op == 4'd7) && res[0]) ||
               ((op == 4'd5 || op == 4'd8) && (res[1:0] != 2'b00));
`else
        excp = 1'b0;
`endif
        bad  = excp ? res : 32'h0;
        rfwe = m_bus[37]  && !excp;
        hiwe = m_bus[207] && !excp;
        lowe = m_bus[174] && !excp;
        ewb = {hiwe, m_bus[206:175], lowe, m_bus[173:142], m_bus[75:44], rfwe, m_bus[36:32], wd};
        eid = {hiwe, m_bus[206:175], lowe, m_bus[173:142], rfwe, m_bus[36:32], wd};
        chk("model_wb", 256'(mem_to_wb_bus), 256'(ewb));
        chk("model_id", 256'(mem_to_id_bus), 256'(eid));
        chk("model_excp", 256'(mem_excp), 256'(excp));
        chk("model_badvaddr", 256'(mem_badvaddr), 256'(bad));
    endtask

    task automatic drive(input logic r, input logic [5:0] st, input logic [211:0] b, input logic [31:0] rd);
        rst = r;
        stall = st;
        ex_to_mem_bus = b;
        data_sram_rdata = rd;
        #1;
        compare_model();
    endtask

    // Advance one clock and move the reference stage along with it
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_bus = '0; m_first = 1'b1; m_word = 32'h0;
        end else if (stall[3] && !stall[4]) begin
            m_bus = '0; m_first = 1'b1;
        end else if (!stall[3]) begin
            m_bus = ex_to_mem_bus; m_first = 1'b1;
        end else if (m_first) begin
            m_word = data_sram_rdata; m_first = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [211:0] p;
        logic [223:0] rb;
        int unsigned  sel;
        rst = 1'b1; stall = 6'd0; ex_to_mem_bus = '0; data_sram_rdata = 32'h0;
        @(posedge clk); @(posedge clk);
        m_bus = '0; m_first = 1'b1; m_word = 32'h0;
        @(negedge clk);

        drive(1'b0, 6'd0, '0, 32'h5555_AAAA);
        chk("reset_wb", 256'(mem_to_wb_bus), 256'd0);
        chk("reset_id", 256'(mem_to_id_bus), 256'd0);
        chk("reset_excp", 256'(mem_excp), 256'd0);
        tick();

        drive(1'b0, 6'd0, pkt(4'd1, 32'h1003, 1'b1, 1'b1, 5'd5, 32'h400), 32'h0); tick();
        drive(1'b0, 6'd0, pkt(4'd2, 32'h1003, 1'b1, 1'b1, 5'd5, 32'h404), 32'h80FF_1234);
        chk("lb", 256'(mem_to_wb_bus[31:0]), 256'(32'hFFFF_FF80));
        tick();
        drive(1'b0, 6'd0, pkt(4'd3, 32'h1002, 1'b1, 1'b1, 5'd6, 32'h408), 32'h80FF_1234);
        chk("lbu", 256'(mem_to_wb_bus[31:0]), 256'(32'h0000_0080));
        tick();
        drive(1'b0, 6'd0, pkt(4'd4, 32'h1000, 1'b1, 1'b1, 5'd7, 32'h40C), 32'h80FF_1234);
        chk("lh", 256'(mem_to_wb_bus[31:0]), 256'(32'hFFFF_80FF));
        tick();
        drive(1'b0, 6'd0, pkt(4'd5, 32'h2000, 1'b1, 1'b1, 5'd3, 32'h410), 32'h80FF_1234);
        chk("lhu", 256'(mem_to_wb_bus[31:0]), 256'(32'h0000_1234));
        tick();

        drive(1'b0, 6'b011000, '0, 32'hDEAD_BEEF);
        chk("lw_stall0", 256'(mem_to_wb_bus[31:0]), 256'(32'hDEAD_BEEF));
        tick();
        for (int i = 1; i < 3; i++) begin
            drive(1'b0, 6'b011000, '0, 32'h0);
            chk("lw_stall_hold", 256'(mem_to_wb_bus[31:0]), 256'(32'hDEAD_BEEF));
            tick();
        end
        drive(1'b0, 6'd0, pkt(4'd0, 32'h0, 1'b0, 1'b1, 5'd9, 32'h500), 32'h0);
        chk("lw_release", 256'(mem_to_wb_bus[31:0]), 256'(32'hDEAD_BEEF));
        chk("lw_release_rfwe", 256'(mem_to_wb_bus[37]), 256'd1);
        tick();

        drive(1'b0, 6'b001000, pkt(4'd5, 32'h3000, 1'b1, 1'b1, 5'd4, 32'h504), 32'h1);
        tick();
        drive(1'b0, 6'b011000, '0, 32'h2);
        chk("bubble_wb", 256'(mem_to_wb_bus), 256'd0);
        chk("bubble_id", 256'(mem_to_id_bus), 256'd0);
        tick();

        drive(1'b0, 6'd0, pkt(4'd5, 32'h3000, 1'b1, 1'b1, 5'd4, 32'h508), 32'h3); tick();
        drive(1'b0, 6'b011000, '0, 32'hCAFE_F00D); tick();
        drive(1'b1, 6'b011000, '0, 32'h1234_5678); tick();
        drive(1'b0, 6'b011000, '0, 32'h1111_1111);
        chk("rst_mid_wb", 256'(mem_to_wb_bus), 256'd0);
        chk("rst_mid_id", 256'(mem_to_id_bus), 256'd0);
        tick();

        p = pkt(4'd0, 32'h0000_AAAA, 1'b0, 1'b1, 5'd2, 32'h600);
        p[108] = 1'b1; p[107:76] = 32'h1234_5678;
        p[207] = 1'b1; p[206:175] = 32'h5;
        drive(1'b0, 6'd0, p, 32'h0); tick();
        drive(1'b0, 6'd0, pkt(4'd5, 32'h2002, 1'b1, 1'b1, 5'd8, 32'h604), 32'h0);
        chk("rhi_wdata", 256'(mem_to_wb_bus[31:0]), 256'(32'h1234_5678));
        chk("hi_wb", 256'(mem_to_wb_bus[135:103]), 256'({1'b1, 32'h5}));
        chk("hi_id", 256'(mem_to_id_bus[103:71]), 256'({1'b1, 32'h5}));
        tick();
        drive(1'b0, 6'd0, '0, 32'h0);
`ifdef MEM_ADDR_EXC_EN
        chk("exc_flag", 256'(mem_excp), 256'd1);
        chk("exc_badvaddr", 256'(mem_badvaddr), 256'(32'h2002));
        chk("exc_rfwe", 256'(mem_to_wb_bus[37]), 256'd0);
`else
        chk("exc_flag", 256'(mem_excp), 256'd0);
        chk("exc_rfwe", 256'(mem_to_wb_bus[37]), 256'd1);
`endif
        tick();

        for (int n = 0; n < 800; n++) begin
            rb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            p = rb[211:0];
            p[211:208] = 4'($urandom_range(0, 15));
            p[108] = ($urandom_range(0, 7) == 0);
            p[141] = ($urandom_range(0, 7) == 0);
            p[38]  = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 7);
            drive(($urandom_range(0, 59) == 0),
                  (sel < 4) ? 6'd0 : (sel < 6) ? 6'b011000 : (sel == 6) ? 6'b001000 : 6'($urandom),
                  p, $urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
